// File: rtl/sha256_pkg.sv
// SHA-256 constants, the block FSM state type and the round/schedule helper functions
// shared by the streaming core and its round datapath.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Eight independent mod-2^32 additions; no carry crosses a word boundary.
    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: {a..h} in, {a..h} out, a in bits 255:224.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] nxt
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = st;
    assign t1  = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2  = big_sigma0(a) + maj(a, b, c);
    assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream.sv
// Multi-block SHA-256 core: accepts pre-padded 512-bit blocks, chains H across a message
// and evaluates ROUNDS_PER_CYCLE rounds per clock.
module sha256_stream
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BLK_VALID,
    output logic         BLK_READY,
    input  logic         BLK_FIRST,
    input  logic         BLK_LAST,
    input  logic [511:0] BLK_DATA,
    output logic         BUSY,
    output logic         DONE,
    output logic [255:0] DIGEST,
    output logic [1:0]   dbg_state
);

    localparam int         R                = ROUNDS_PER_CYCLE;
    localparam int         CYCLES_PER_BLOCK = 64 / R;
    localparam logic [6:0] T_FINAL          = 7'(64 - R);

    if (!(R == 1 || R == 2 || R == 4 || R == 8) || CYCLES_PER_BLOCK * R != 64) begin : g_bad_rounds
        $error("sha256_stream: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t       state, state_nxt;
    logic [6:0]   t;
    logic [255:0] h, wv;
    logic [31:0]  w   [16];
    logic [31:0]  ext [16+R];
    logic         last_q, chain_active;
    logic         accept, use_iv;
    logic [255:0] base, h_sum, round_out;

    // Handshake: a block transfers on a rising CLK edge where BLK_VALID and BLK_READY are
    // both high; BLK_DATA/BLK_FIRST/BLK_LAST are sampled only then, and the producer keeps
    // them stable until that edge. BLK_VALID with BLK_READY low has no effect.
    assign accept    = BLK_VALID & BLK_READY;
    assign use_iv    = BLK_FIRST | ~chain_active;
    assign base      = use_iv ? IV : h;
    assign h_sum     = add_words(h, wv);
    assign dbg_state = state;

    // ext[0..15] is W[t..t+15]; ext[16..15+R] are the R schedule words produced this cycle.
    always_comb begin
        for (int j = 0; j < 16 + R; j++) ext[j] = '0;
        for (int j = 0; j < 16; j++) ext[j] = w[j];
        for (int j = 0; j < R; j++)
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end

    for (genvar i = 0; i < R; i++) begin : g_round
        logic [5:0]   kidx;
        logic [255:0] si, so;
        if (i == 0) begin : g_head
            assign si = wv;
        end else begin : g_link
            assign si = g_round[i-1].so;
        end
        assign kidx = t[5:0] + 6'(i);
        sha256_round u_round (
            .st  (si),
            .w   (ext[i]),
            .k   (K[kidx]),
            .nxt (so)
        );
    end
    assign round_out = g_round[R-1].so;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BLK_READY = 1'b0;
        BUSY      = 1'b0;
        case (state)
            IDLE: begin
                BLK_READY = 1'b1;
                if (BLK_VALID) state_nxt = ROUND;
            end
            ROUND: begin
                BUSY = 1'b1;
                if (t == T_FINAL) state_nxt = UPDATE;
            end
            UPDATE: begin
                BUSY      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            t            <= '0;
            h            <= IV;
            wv           <= '0;
            last_q       <= 1'b0;
            chain_active <= 1'b0;
            DONE         <= 1'b0;
            DIGEST       <= '0;
            for (int j = 0; j < 16; j++) w[j] <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int j = 0; j < 16; j++) w[j] <= BLK_DATA[511 - 32*j -: 32];
                        last_q <= BLK_LAST;
                        wv     <= base;
                        t      <= '0;
                        if (use_iv) h <= IV;
                    end
                end
                ROUND: begin
                    wv <= round_out;
                    for (int j = 0; j < 16; j++) w[j] <= ext[j+R];
                    t  <= t + 7'(R);
                end
                UPDATE: begin
                    h <= h_sum;
                    if (last_q) begin
                        DIGEST       <= h_sum;
                        DONE         <= 1'b1;
                        chain_active <= 1'b0;
                    end else begin
                        chain_active <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_stream.sv
// Bench for sha256_stream: one R=1 and one R=4 instance, known-answer vectors, multi-block
// sequences, reset mid-compression and random messages against a reference hash model.
module tb_sha256_stream;
    import sha256_pkg::IDLE;
    import sha256_pkg::ROUND;

    localparam logic [255:0] IV_TB = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] BLK_TEST  = {32'h74657374, 32'h80000000, 416'h0, 32'h00000020};
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_NIST1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_NIST2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_TEST  = 256'h9f86d081884c7d659a2feaa0c55ad015a3bf4f1b2b0b822cd15d6c15b0f00a08;
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_NIST  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        int           inst;
        logic [511:0] blk;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs: index 0 is R=1, index 1 is R=4 ----------------
    logic [1:0]        vld = '0;
    logic [1:0]        fst = '0;
    logic [1:0]        lst = '0;
    logic [1:0][511:0] dat = '0;
    logic [1:0]        rdy, busy, done;
    logic [1:0][255:0] dig;
    logic [1:0][1:0]   dbg;

    sha256_stream #(.ROUNDS_PER_CYCLE(1)) u_dut_r1 (
        .CLK(clk), .RST(rst), .BLK_VALID(vld[0]), .BLK_READY(rdy[0]), .BLK_FIRST(fst[0]),
        .BLK_LAST(lst[0]), .BLK_DATA(dat[0]), .BUSY(busy[0]), .DONE(done[0]),
        .DIGEST(dig[0]), .dbg_state(dbg[0])
    );

    sha256_stream #(.ROUNDS_PER_CYCLE(4)) u_dut_r4 (
        .CLK(clk), .RST(rst), .BLK_VALID(vld[1]), .BLK_READY(rdy[1]), .BLK_FIRST(fst[1]),
        .BLK_LAST(lst[1]), .BLK_DATA(dat[1]), .BUSY(busy[1]), .DONE(done[1]),
        .DIGEST(dig[1]), .dbg_state(dbg[1])
    );

    // ---------------- bookkeeping ----------------
    int           total = 0;
    int           bad   = 0;
    int           done_cnt [2] = '{0, 0};
    int           done_cyc [2] = '{0, 0};
    logic [255:0] last_dig [2];
    int           acc_cyc  = 0;
    logic         acc_done = 1'b0;
    bit           sb_on    = 1'b0;
    logic [255:0] exp_q [$];
    logic [255:0] sb_e;

    task automatic chkw(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return hout;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // ---------------- monitor + scoreboard ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done[k]) begin
                done_cnt[k] = done_cnt[k] + 1;
                done_cyc[k] = cyc;
                last_dig[k] = dig[k];
                if (k == 1 && sb_on) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected_done got=%h exp=none", dig[k]);
                    end else begin
                        sb_e = exp_q.pop_front();
                        if (dig[k] !== sb_e) begin
                            bad++;
                            $display("FAIL sb_digest got=%h exp=%h", dig[k], sb_e);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int k, input logic [511:0] d, input logic f, input logic l, input logic hold);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        dat[k] = d;
        fst[k] = f;
        lst[k] = l;
        vld[k] = 1'b1;
        while (!acc && n < 200) begin
            acc      = rdy[k];
            acc_done = done[k];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout inst=%0d got=no_ready exp=ready_within_200", k);
        end
        acc_cyc = cyc;
        if (!hold) vld[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt[k] < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki(name, (done_cnt[k] >= target) ? target : done_cnt[k], target);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t         tv [4];
        int           base, a1, a2, gap, nb, n;
        logic [255:0] hm;
        logic [511:0] blk;
        logic         f;

        tv[0] = '{0, BLK_TEST,  DIG_TEST,  65};
        tv[1] = '{1, BLK_ABC,   DIG_ABC,   17};
        tv[2] = '{1, BLK_EMPTY, DIG_EMPTY, 17};
        tv[3] = '{0, BLK_ABC,   DIG_ABC,   65};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk1("rst_ready", rdy[k], 1'b1);
            chk1("rst_busy", busy[k], 1'b0);
            chk1("rst_done", done[k], 1'b0);
            chkw("rst_digest", dig[k], 256'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // known-answer single-block vectors with latency
        for (int i = 0; i < 4; i++) begin
            base = done_cnt[tv[i].inst];
            send(tv[i].inst, tv[i].blk, 1'b1, 1'b1, 1'b0);
            wait_done(tv[i].inst, base + 1, 200, "kat_done");
            chkw("kat_digest", last_dig[tv[i].inst], tv[i].exp);
            chki("kat_latency", done_cyc[tv[i].inst] - acc_cyc, tv[i].lat);
        end

        // back-to-back with BLK_VALID held high: second accept on the DONE cycle
        base = done_cnt[0];
        send(0, BLK_EMPTY, 1'b1, 1'b1, 1'b1);
        a1 = acc_cyc;
        send(0, BLK_ABC, 1'b1, 1'b1, 1'b0);
        a2 = acc_cyc;
        chk1("b2b_accept_with_done", acc_done, 1'b1);
        chki("b2b_spacing", a2 - a1, 66);
        chkw("b2b_digest1", last_dig[0], DIG_EMPTY);
        wait_done(0, base + 2, 200, "b2b_done2");
        chkw("b2b_digest2", last_dig[0], DIG_ABC);

        // two-block message, exactly one DONE
        base = done_cnt[0];
        send(0, BLK_NIST1, 1'b1, 1'b0, 1'b0);
        send(0, BLK_NIST2, 1'b0, 1'b1, 1'b0);
        wait_done(0, base + 1, 200, "nist_done");
        repeat (80) begin @(posedge clk); #1; end
        chki("nist_done_count", done_cnt[0] - base, 1);
        chkw("nist_digest", last_dig[0], DIG_NIST);

        // FIRST mid-message abandons the chain silently
        base = done_cnt[0];
        send(0, BLK_NIST1, 1'b1, 1'b0, 1'b0);
        send(0, BLK_ABC, 1'b1, 1'b1, 1'b0);
        wait_done(0, base + 1, 200, "abandon_done");
        repeat (80) begin @(posedge clk); #1; end
        chki("abandon_done_count", done_cnt[0] - base, 1);
        chkw("abandon_digest", last_dig[0], DIG_ABC);

        // reset at cycle 30 of ROUND
        send(0, BLK_TEST, 1'b1, 1'b1, 1'b0);
        repeat (29) begin @(posedge clk); #1; end
        chk1("mid_busy", busy[0], 1'b1);
        chk1("mid_ready", rdy[0], 1'b0);
        chki("mid_state", int'(dbg[0]), int'(ROUND));
        base = done_cnt[0];
        rst = 1'b1;
        #1;
        chk1("rstmid_ready", rdy[0], 1'b1);
        chk1("rstmid_busy", busy[0], 1'b0);
        chkw("rstmid_digest", dig[0], 256'h0);
        chki("rstmid_state", int'(dbg[0]), int'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (80) begin @(posedge clk); #1; end
        chki("rstmid_no_done", done_cnt[0] - base, 0);
        send(0, BLK_TEST, 1'b0, 1'b1, 1'b0);
        wait_done(0, base + 1, 200, "post_rst_done");
        chkw("post_rst_digest", last_dig[0], DIG_TEST);

        // random multi-block messages on the R=4 instance against the model
        sb_on = 1'b1;
        for (int m = 0; m < 10; m++) begin
            nb = $urandom_range(1, 3);
            hm = IV_TB;
            for (int b = 0; b < nb; b++) begin
                blk = rand_block();
                hm  = model_compress(hm, blk);
                f   = (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
                if (b == nb - 1) exp_q.push_back(hm);
                send(1, blk, f, b == nb - 1, 1'b0);
                gap = $urandom_range(0, 3);
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
